i8255x: RTL and testbench

I8255X -- requirements
Module: i8255x

---
 rtl/i8255x_if.sv | 13 +
 rtl/i8255x.sv | 253 +++++++++++++++++++++++++
 tb/tb_i8255x.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/i8255x_if.sv
// Host bus of the i8255x programmable peripheral interface: register select,
// write/read data and the active-high chip-select and strobes.
interface i8255x_if;
    logic [1:0] addr;
    logic [7:0] idata;
    logic [7:0] odata;
    logic       cs;
    logic       we;
    logic       oe;

    modport master (output addr, idata, cs, we, oe, input odata);
    modport slave  (input addr, idata, cs, we, oe, output odata);
endinterface

// File: rtl/i8255x.sv
// i8255x: 8255-style PPI with mode 0 on all ports and mode-1 strobed I/O on A/B.
// Optional macro I8255X_CPC_QUIRK_EN ORs 4'h2 into the port C upper read nibble.
module i8255x #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_MODE  = 8'h9B
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    i8255x_if.slave    bus,
    input  logic [7:0] ipa,
    output logic [7:0] opa,
    input  logic [7:0] ipb,
    output logic [7:0] opb,
    input  logic [7:0] ipc,
    output logic [7:0] opc,
    output logic       intr_a,
    output logic       intr_b
);

    logic [7:0] mode_q;
    logic [7:0] opa_r, opb_r, opc_r;
    logic [7:0] latch_a, latch_b;
    logic       inte_a, inte_b;
    logic       ibf_a, ibf_b;
    logic       intr_a_q, intr_b_q;
    logic       obf_a_n, obf_b_n;
    logic       wr_q, rd_q;
    logic [1:0] rd_addr_q;

    // Handshake pins, bit order {PC2, PC6, PC4}
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0] hs_s, hs_q, hs_fall, hs_rise;

    logic       wr, wr_go, rd, rd_rise, rd_fall;
    logic       a_mode1, a_in, b_mode1, b_in;
    logic       wr_a, wr_b, wr_c, mode_set, bsr;
    logic [2:0] bsr_sel;
    logic       rd_a_rise, rd_a_fall, rd_b_rise, rd_b_fall;
    logic       stb_a_fall, stb_a_rise, ack_a_fall, ack_a_rise;
    logic       stb_b_fall, stb_b_rise, ack_b_fall, ack_b_rise;
    logic [7:0] c_own;
    logic [7:0] rd_a_data, rd_b_data, rd_c_data;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync_q <= '1;
            hs_q   <= '1;
        end else begin
            sync_q[0] <= {ipc[2], ipc[6], ipc[4]};
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            hs_q <= hs_s;
        end
    end

    assign hs_s    = sync_q[SYNC_STAGES-1];
    assign hs_fall = hs_q & ~hs_s;
    assign hs_rise = ~hs_q & hs_s;

    assign wr      = bus.cs & bus.we;
    assign wr_go   = wr & ~wr_q;
    assign rd      = bus.cs & bus.oe;
    assign rd_rise = rd & ~rd_q;
    assign rd_fall = ~rd & rd_q;

    assign a_mode1 = |mode_q[6:5];
    assign a_in    = mode_q[4];
    assign b_mode1 = mode_q[2];
    assign b_in    = mode_q[1];

    assign wr_a     = wr_go && (bus.addr == 2'd0);
    assign wr_b     = wr_go && (bus.addr == 2'd1);
    assign wr_c     = wr_go && (bus.addr == 2'd2);
    assign mode_set = wr_go && (bus.addr == 2'd3) && bus.idata[7];
    assign bsr      = wr_go && (bus.addr == 2'd3) && !bus.idata[7];
    assign bsr_sel  = bus.idata[3:1];

    // Fall-side clears use the address captured at the read's rising edge
    assign rd_a_rise = rd_rise && (bus.addr == 2'd0);
    assign rd_b_rise = rd_rise && (bus.addr == 2'd1);
    assign rd_a_fall = rd_fall && (rd_addr_q == 2'd0);
    assign rd_b_fall = rd_fall && (rd_addr_q == 2'd1);

    assign stb_a_fall = a_mode1 &  a_in & hs_fall[0];
    assign stb_a_rise = a_mode1 &  a_in & hs_rise[0];
    assign ack_a_fall = a_mode1 & ~a_in & hs_fall[1];
    assign ack_a_rise = a_mode1 & ~a_in & hs_rise[1];
    assign stb_b_fall = b_mode1 &  b_in & hs_fall[2];
    assign stb_b_rise = b_mode1 &  b_in & hs_rise[2];
    assign ack_b_fall = b_mode1 & ~b_in & hs_fall[2];
    assign ack_b_rise = b_mode1 & ~b_in & hs_rise[2];

    always_comb begin
        c_own = '0;
        if (a_mode1) begin
            c_own[3] = 1'b1;
            if (a_in) c_own[5:4] = 2'b11;
            else      c_own[7:6] = 2'b11;
        end
        if (b_mode1) c_own[2:0] = 3'b111;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mode_q    <= RESET_MODE;
            opa_r     <= '0;
            opb_r     <= '0;
            opc_r     <= '0;
            latch_a   <= '0;
            latch_b   <= '0;
            inte_a    <= 1'b0;
            inte_b    <= 1'b0;
            ibf_a     <= 1'b0;
            ibf_b     <= 1'b0;
            intr_a_q  <= 1'b0;
            intr_b_q  <= 1'b0;
            obf_a_n   <= 1'b1;
            obf_b_n   <= 1'b1;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            wr_q <= wr;
            rd_q <= rd;
            if (rd_rise) rd_addr_q <= bus.addr;

            if (mode_set) begin
                mode_q   <= bus.idata;
                opa_r    <= '0;
                opb_r    <= '0;
                opc_r    <= '0;
                inte_a   <= 1'b0;
                inte_b   <= 1'b0;
                ibf_a    <= 1'b0;
                ibf_b    <= 1'b0;
                intr_a_q <= 1'b0;
                intr_b_q <= 1'b0;
                obf_a_n  <= 1'b1;
                obf_b_n  <= 1'b1;
            end else begin
                if (wr_a) opa_r <= bus.idata;
                if (wr_b) opb_r <= bus.idata;
                if (wr_c) opc_r <= (opc_r & c_own) | (bus.idata & ~c_own);

                // BSR on an INTE position updates the enable, never the pin latch
                if (bsr) begin
                    if (a_mode1 && ((a_in && bsr_sel == 3'd4) || (!a_in && bsr_sel == 3'd6)))
                        inte_a <= bus.idata[0];
                    else if (b_mode1 && bsr_sel == 3'd2)
                        inte_b <= bus.idata[0];
                    else
                        opc_r[bsr_sel] <= bus.idata[0];
                end

                // Clears are written before sets so a coincident set wins
                if (a_mode1 && a_in) begin
                    if (rd_a_rise) intr_a_q <= 1'b0;
                    if (rd_a_fall) ibf_a <= 1'b0;
                end
                if (a_mode1 && !a_in && wr_a) begin
                    obf_a_n  <= 1'b0;
                    intr_a_q <= 1'b0;
                end
                if (stb_a_fall) begin
                    latch_a <= ipa;
                    ibf_a   <= 1'b1;
                end
                if (stb_a_rise && ibf_a && inte_a) intr_a_q <= 1'b1;
                if (ack_a_fall) obf_a_n <= 1'b1;
                if (ack_a_rise && inte_a) intr_a_q <= 1'b1;

                if (b_mode1 && b_in) begin
                    if (rd_b_rise) intr_b_q <= 1'b0;
                    if (rd_b_fall) ibf_b <= 1'b0;
                end
                if (b_mode1 && !b_in && wr_b) begin
                    obf_b_n  <= 1'b0;
                    intr_b_q <= 1'b0;
                end
                if (stb_b_fall) begin
                    latch_b <= ipb;
                    ibf_b   <= 1'b1;
                end
                if (stb_b_rise && ibf_b && inte_b) intr_b_q <= 1'b1;
                if (ack_b_fall) obf_b_n <= 1'b1;
                if (ack_b_rise && inte_b) intr_b_q <= 1'b1;
            end
        end
    end

    assign opa    = a_in ? 8'hFF : opa_r;
    assign opb    = b_in ? 8'hFF : opb_r;
    assign intr_a = intr_a_q;
    assign intr_b = intr_b_q;

    always_comb begin
        opc[7:4] = mode_q[3] ? 4'hF : opc_r[7:4];
        opc[3:0] = mode_q[0] ? 4'hF : opc_r[3:0];
        if (a_mode1) begin
            opc[3] = intr_a_q;
            if (a_in) begin
                opc[4] = 1'b1;
                opc[5] = ibf_a;
            end else begin
                opc[6] = 1'b1;
                opc[7] = obf_a_n;
            end
        end
        if (b_mode1) begin
            opc[0] = intr_b_q;
            opc[1] = b_in ? ibf_b : obf_b_n;
            opc[2] = 1'b1;
        end
    end

    always_comb begin
        rd_a_data = a_in ? (a_mode1 ? latch_a : ipa) : opa_r;
        rd_b_data = b_in ? (b_mode1 ? latch_b : ipb) : opb_r;

        rd_c_data[7:4] = mode_q[3] ? ipc[7:4] : opc_r[7:4];
        rd_c_data[3:0] = mode_q[0] ? ipc[3:0] : opc_r[3:0];
        if (a_mode1) begin
            rd_c_data[3] = intr_a_q;
            if (a_in) begin
                rd_c_data[4] = inte_a;
                rd_c_data[5] = ibf_a;
            end else begin
                rd_c_data[6] = inte_a;
                rd_c_data[7] = obf_a_n;
            end
        end
        if (b_mode1) begin
            rd_c_data[0] = intr_b_q;
            rd_c_data[1] = b_in ? ibf_b : obf_b_n;
            rd_c_data[2] = inte_b;
        end
`ifdef I8255X_CPC_QUIRK_EN
        if (mode_q[6:4] == 3'b010 && !mode_q[2] && mode_q[3])
            rd_c_data[7:4] = rd_c_data[7:4] | 4'h2;
`endif
    end

    always_comb begin
        bus.odata = '0;
        case (bus.addr)
            2'd0:    bus.odata = rd_a_data;
            2'd1:    bus.odata = rd_b_data;
            2'd2:    bus.odata = rd_c_data;
            default: bus.odata = mode_q;
        endcase
    end

endmodule

// File: tb/tb_i8255x.sv
// Directed bench for i8255x: reset, mode 0, mode-1 strobed input/output,
// coincident strobe/read, reset mid-handshake and the port C quirk option.
module tb_i8255x;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [7:0] ipa, ipb, ipc;
    logic [7:0] opa, opb, opc;
    logic       intr_a, intr_b;
    int         total = 0;
    int         bad   = 0;

    i8255x_if bus();

    i8255x #(.SYNC_STAGES(2), .RESET_MODE(8'h9B)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus),
        .ipa     (ipa),
        .opa     (opa),
        .ipb     (ipb),
        .opb     (opb),
        .ipc     (ipc),
        .opc     (opc),
        .intr_a  (intr_a),
        .intr_b  (intr_b)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        bus.addr = a; bus.idata = d; bus.cs = 1'b1; bus.we = 1'b1;
        tick();
        bus.we = 1'b0; bus.cs = 1'b0;
        tick();
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        bus.addr = a; bus.cs = 1'b1; bus.oe = 1'b1;
        #1;
        check(tag, bus.odata, exp);
        tick();
        bus.oe = 1'b0; bus.cs = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        ipa = 8'h00; ipb = 8'h00; ipc = 8'hFF;
        bus.addr = '0; bus.idata = '0; bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b0;
        tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_opa", opa, 8'hFF);
        check("rst_opb", opb, 8'hFF);
        check("rst_opc", opc, 8'hFF);
        check("rst_intr_a", {7'b0, intr_a}, 8'h00);
        check("rst_intr_b", {7'b0, intr_b}, 8'h00);
        read_chk("rst_ctl", 2'd3, 8'h9B);

        // Mode 0, all outputs
        wr_reg(2'd3, 8'h80);
        check("m0_opa_clr", opa, 8'h00);
        wr_reg(2'd0, 8'h3C);
        check("m0_opa", opa, 8'h3C);
        wr_reg(2'd2, 8'hA5);
        check("m0_opc", opc, 8'hA5);
        wr_reg(2'd3, 8'h0E);
        check("m0_bsr_clr7", opc, 8'h25);
        read_chk("m0_rd_c", 2'd2, 8'h25);

        // Mode 0, A and B input, C output
        wr_reg(2'd3, 8'h92);
        ipa = 8'h77; ipb = 8'h88;
        check("m0_in_opa", opa, 8'hFF);
        check("m0_in_opb", opb, 8'hFF);
        check("m0_in_opc", opc, 8'h00);
        read_chk("m0_rd_a", 2'd0, 8'h77);
        read_chk("m0_rd_b", 2'd1, 8'h88);

        // A mode-1 input handshake
        wr_reg(2'd3, 8'hB0);
        check("a_in_opc", opc, 8'h10);
        wr_reg(2'd3, 8'h09);
        read_chk("a_in_rd_c", 2'd2, 8'h10);
        ipa = 8'h5A;
        ipc = 8'hEF;
        ticks(2);
        check("a_ibf_early", opc, 8'h10);
        tick();
        check("a_ibf_set", opc, 8'h30);
        tick();
        ipc = 8'hFF;
        ticks(2);
        check("a_intr_early", {7'b0, intr_a}, 8'h00);
        tick();
        check("a_intr_set", {7'b0, intr_a}, 8'h01);
        check("a_opc_intr", opc, 8'h38);
        bus.addr = 2'd0; bus.cs = 1'b1; bus.oe = 1'b1;
        #1;
        check("a_rd_latch", bus.odata, 8'h5A);
        tick();
        check("a_intr_clr_rise", {7'b0, intr_a}, 8'h00);
        check("a_ibf_hold_rise", opc, 8'h30);
        bus.oe = 1'b0; bus.cs = 1'b0;
        tick();
        check("a_ibf_clr_fall", opc, 8'h10);

        // STB_A# fall lands on the same edge as the A-read fall
        ipa = 8'h6E;
        ipc = 8'hEF;
        bus.addr = 2'd0; bus.cs = 1'b1; bus.oe = 1'b1;
        ticks(2);
        bus.oe = 1'b0; bus.cs = 1'b0;
        tick();
        check("coinc_ibf", opc, 8'h30);
        read_chk("coinc_latch", 2'd0, 8'h6E);
        check("coinc_ibf_clr", opc, 8'h10);
        ipc = 8'hFF;
        ticks(4);
        check("coinc_no_intr", {7'b0, intr_a}, 8'h00);

        // B mode-1 output handshake
        wr_reg(2'd3, 8'h84);
        check("b_out_opc", opc, 8'h06);
        check("b_out_opb_clr", opb, 8'h00);
        wr_reg(2'd3, 8'h05);
        read_chk("b_out_rd_c", 2'd2, 8'h06);
        wr_reg(2'd1, 8'hC3);
        check("b_out_opb", opb, 8'hC3);
        check("b_obf_low", opc, 8'h04);
        read_chk("b_rd_b", 2'd1, 8'hC3);
        ipc = 8'hFB;
        ticks(2);
        check("b_obf_early", opc, 8'h04);
        tick();
        check("b_obf_high", opc, 8'h06);
        tick();
        ipc = 8'hFF;
        ticks(2);
        check("b_intr_early", {7'b0, intr_b}, 8'h00);
        tick();
        check("b_intr_set", {7'b0, intr_b}, 8'h01);
        check("b_opc_intr", opc, 8'h07);
        wr_reg(2'd1, 8'h5A);
        check("b_wr_clr_intr", {7'b0, intr_b}, 8'h00);
        check("b_wr_obf_low", opc, 8'h04);

        // Reset in the middle of an STB_A# pulse
        wr_reg(2'd3, 8'hB0);
        wr_reg(2'd3, 8'h09);
        ipc = 8'hEF;
        ticks(3);
        check("mid_ibf_set", opc, 8'h30);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_intr", {7'b0, intr_a}, 8'h00);
        check("mid_rst_opc", opc, 8'hFF);
        read_chk("mid_rst_ctl", 2'd3, 8'h9B);
        ticks(4);
        wr_reg(2'd3, 8'hB0);
        check("mid_ibf_clr", opc, 8'h10);
        wr_reg(2'd3, 8'h09);
        ipc = 8'hFF;
        ticks(4);
        check("mid_no_intr", {7'b0, intr_a}, 8'h00);
        check("mid_opc_idle", opc, 8'h10);

        // Port C upper read quirk
        ipc = 8'h00;
        ticks(4);
        wr_reg(2'd3, 8'hA8);
`ifdef I8255X_CPC_QUIRK_EN
        read_chk("quirk_a8", 2'd2, 8'hA0);
`else
        read_chk("quirk_a8", 2'd2, 8'h80);
`endif
        wr_reg(2'd3, 8'hA0);
        read_chk("quirk_a0", 2'd2, 8'h80);
        check("quirk_a0_opc", opc, 8'hC0);
        ipc = 8'hFF;
        ticks(4);
        check("quirk_no_intr", {7'b0, intr_a}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
